// File: rtl/dma_priority_sequencer_pkg.sv
// Shared constants and types for the DMA channel arbiter / hold sequencer.
package dmaRegConfigPkg;

   localparam int CHANNELS = 4;
   localparam int CH_W     = $clog2(CHANNELS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } arbState_t;

   typedef enum logic {
      PRIO_FIXED    = 1'b0,
      PRIO_ROTATING = 1'b1
   } prioMode_t;

   // Pointer names the lowest-priority channel; search starts one above it.
   localparam logic [CH_W-1:0] PTR_RESET = CH_W'(CHANNELS - 1);

endpackage

// File: rtl/dma_priority_sequencer_encoder.sv
// Combinational rotating priority search: first pending channel at or after ptr+1,
// wrapping around.
module dmaPriorityEncoder
   import dmaRegConfigPkg::*;
(
   input  logic [CHANNELS-1:0] pending,
   input  logic [CH_W-1:0]     ptr,
   output logic [CH_W-1:0]     winner,
   output logic                found
);

   logic [CH_W-1:0] idx;

   // Walk from the farthest offset back to the nearest so the nearest wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         idx = CH_W'((int'(ptr) + i) % CHANNELS);
         if (pending[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_sequencer.sv
// DMA arbiter and HRQ/HLDA hold sequencer. Define ROTATING_PRIORITY_EN to make the
// lowest-priority pointer follow the last serviced channel; otherwise channel 0 always wins.
module dma_priority_sequencer
   import dmaRegConfigPkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [CHANNELS-1:0] DREQ,
   input  logic [CHANNELS-1:0] mask,
   input  logic [CHANNELS-1:0] demandMode,
   input  logic                HLDA,
   input  logic                transferDone,
   input  logic                tc,
   input  logic                eopIn,
   output logic                HRQ,
   output logic [CHANNELS-1:0] DACK,
   output logic                grantValid,
   output logic [CH_W-1:0]     grantChannel,
   output logic                serviceEnd
);

`ifdef ROTATING_PRIORITY_EN
   localparam prioMode_t PRIO_MODE = PRIO_ROTATING;
`else
   localparam prioMode_t PRIO_MODE = PRIO_FIXED;
`endif

   arbState_t           state, state_nxt;
   logic [CHANNELS-1:0] pending;
   logic [CH_W-1:0]     win_ch, gnt_ch, prio_ptr;
   logic                win_found;
   logic                term_evt, term_q;
   logic                hrq_d, gv_d, se_d;
   logic [CHANNELS-1:0] dack_d;

   assign pending = DREQ & ~mask;

   dmaPriorityEncoder u_enc (
      .pending (pending),
      .ptr     (prio_ptr),
      .winner  (win_ch),
      .found   (win_found)
   );

   generate
      if (PRIO_MODE == PRIO_ROTATING) begin : g_rot
         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET)
               prio_ptr <= PTR_RESET;
            else if (state == ST_GRANT && state_nxt == ST_RELEASE)
               prio_ptr <= gnt_ch;
         end
      end else begin : g_fix
         assign prio_ptr = PTR_RESET;
      end
   endgenerate

   // A completion counts only while the bus is still ours.
   assign term_evt = (state == ST_GRANT) && HLDA && transferDone && (tc || eopIn);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= ST_IDLE;
         gnt_ch <= '0;
         term_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         term_q <= term_evt;
         if (state == ST_IDLE && win_found)
            gnt_ch <= win_ch;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (win_found) state_nxt = ST_REQUEST;
         ST_REQUEST: if (HLDA) state_nxt = ST_GRANT;
         ST_GRANT: begin
            if (!HLDA)
               state_nxt = ST_IDLE;
            else if (transferDone) begin
               if (tc || eopIn || !demandMode[gnt_ch])
                  state_nxt = ST_RELEASE;
               else if (!(DREQ[gnt_ch] && !mask[gnt_ch]))
                  state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: if (!HLDA) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Output register inputs; preemption drops DACK/HRQ on the very edge HLDA is seen low.
   always_comb begin
      hrq_d  = 1'b0;
      gv_d   = 1'b0;
      dack_d = '0;
      se_d   = term_q;
      if (state == ST_REQUEST)
         hrq_d = 1'b1;
      if (state == ST_GRANT && HLDA) begin
         hrq_d          = 1'b1;
         gv_d           = 1'b1;
         dack_d[gnt_ch] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         HRQ        <= 1'b0;
         DACK       <= '0;
         grantValid <= 1'b0;
         serviceEnd <= 1'b0;
      end else begin
         HRQ        <= hrq_d;
         DACK       <= dack_d;
         grantValid <= gv_d;
         serviceEnd <= se_d;
      end
   end

   assign grantChannel = gnt_ch;

endmodule
